// File: rtl/mux_sel_arbiter.sv
// rtl/mux_sel_arbiter.sv - round-robin select/grant generator for a 4:1 mux (optional MUX_SEL_ARB_TIMEOUT_EN)
module mux_sel_arbiter #(
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       req,
    input  logic             ack,
    output logic             s0,
    output logic             s1,
    output logic [3:0]       grant,
    output logic             valid,
    output logic [CNT_W-1:0] grant_cnt,
    output logic             to
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state, state_nx;
    logic [1:0]       sel, sel_nx;
    logic [1:0]       ptr, ptr_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             tmo_hit;
    logic             rel;
    logic [2:0]       win;

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    // {found, index}: first requester strictly after p, wrapping around
    function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int i = 4; i >= 1; i--) begin
            idx = p + 2'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    assign rel = (state == GRANT) && (ack || tmo_hit);
    assign win = pick(req, rel ? sel : ptr);

    always_comb begin
        state_nx = state;
        sel_nx   = sel;
        ptr_nx   = ptr;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (win[2]) begin
                    sel_nx   = win[1:0];
                    state_nx = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_nx = sel;
                    if (ack) cnt_nx = cnt + 1'b1;
                    if (win[2]) sel_nx = win[1:0];
                    else        state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'd0;
            ptr   <= 2'd3;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            sel   <= sel_nx;
            ptr   <= ptr_nx;
            cnt   <= cnt_nx;
        end
    end

`ifdef MUX_SEL_ARB_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [TW-1:0] tmr;
    logic          to_q;

    assign tmo_hit = (tmr == TW'(TIMEOUT - 1)) && !ack;

    // timer restarts on every fresh grant, including back-to-back reloads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr  <= '0;
            to_q <= 1'b0;
        end else begin
            to_q <= rel && !ack;
            if (state == IDLE || rel) tmr <= '0;
            else                      tmr <= tmr + 1'b1;
        end
    end

    assign to = to_q;
`else
    assign tmo_hit = 1'b0;
    assign to      = 1'b0;
`endif

    assign s0        = sel[0];
    assign s1        = sel[1];
    assign valid     = (state == GRANT);
    assign grant     = valid ? (4'b0001 << sel) : 4'b0000;
    assign grant_cnt = cnt;

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb/tb_mux_sel_arbiter.sv - self-checking bench for mux_sel_arbiter
module tb_mux_sel_arbiter;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       req = 4'b0000;
    logic             ack = 1'b0;
    logic             s0, s1, valid, to;
    logic [3:0]       grant;
    logic [CNT_W-1:0] grant_cnt;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_ptr, m_sel, m_cnt, m_age;
    bit m_busy, m_to;

    mux_sel_arbiter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .ack(ack),
        .s0(s0), .s1(s1), .grant(grant), .valid(valid),
        .grant_cnt(grant_cnt), .to(to)
    );

    always #5 clk = ~clk;

    function automatic int search(input logic [3:0] r, input int p);
        for (int k = 1; k <= 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_ptr = 3; m_sel = 0; m_cnt = 0; m_age = 0; m_busy = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic a);
        int w;
        bit tmo;
        m_to = 0;
        tmo  = 0;
        if (!m_busy) begin
            w = search(r, m_ptr);
            if (w >= 0) begin
                m_busy = 1; m_sel = w; m_age = 0;
            end
        end else begin
`ifdef MUX_SEL_ARB_TIMEOUT_EN
            if (!a && m_age == TIMEOUT - 1) tmo = 1;
`endif
            if (a || tmo) begin
                m_ptr = m_sel;
                if (a) m_cnt = (m_cnt + 1) % (1 << CNT_W);
                else   m_to = 1;
                w = search(r, m_ptr);
                if (w >= 0) begin
                    m_sel = w; m_age = 0;
                end else begin
                    m_busy = 0;
                end
            end else begin
                m_age++;
            end
        end
    endtask

    task automatic tick(input logic [3:0] r, input logic a);
        req = r;
        ack = a;
        @(posedge clk);
        model_edge(r, a);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req = 4'b0000; ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick(4'b0000, 1'b0);
            checks++;
            if ({valid, grant, s1, s0, grant_cnt, to} !== {1'b0, 4'b0000, 2'b00, 8'd0, 1'b0}) begin
                errors++;
                $display("FAIL reset_idle cyc=%0d got valid=%b grant=%b s=%b%b cnt=%0d to=%b want all zero",
                         i, valid, grant, s1, s0, grant_cnt, to);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_sel [5];
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            tick(4'b1111, 1'b1);
            checks++;
            if ({valid, s1, s0, grant} !== {1'b1, exp_sel[i], 4'(4'b0001 << exp_sel[i])}) begin
                errors++;
                $display("FAIL round_robin step=%0d got valid=%b s=%b%b grant=%b want s=%b",
                         i, valid, s1, s0, grant, exp_sel[i]);
            end
        end
        checks++;
        if (grant_cnt !== 8'd4) begin
            errors++;
            $display("FAIL round_robin_cnt got %0d want 4", grant_cnt);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            tick(4'b0100, 1'b0);
            checks++;
            if ({valid, grant, s1, s0} !== {1'b1, 4'b0100, 2'b10}) begin
                errors++;
                $display("FAIL hold cyc=%0d got valid=%b grant=%b s=%b%b want 1 0100 10",
                         i, valid, grant, s1, s0);
            end
        end
        tick(4'b0000, 1'b1);
        checks++;
        if ({valid, grant, grant_cnt} !== {1'b0, 4'b0000, 8'd1}) begin
            errors++;
            $display("FAIL hold_release got valid=%b grant=%b cnt=%0d want 0 0000 1",
                     valid, grant, grant_cnt);
        end
    endtask

    task automatic test_req_drop();
        apply_reset();
        tick(4'b0010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(4'b0000, 1'b0);
            checks++;
            if ({valid, grant} !== {1'b1, 4'b0010}) begin
                errors++;
                $display("FAIL req_drop cyc=%0d got valid=%b grant=%b want 1 0010", i, valid, grant);
            end
        end
        tick(4'b0000, 1'b1);
        checks++;
        if ({valid, grant, grant_cnt} !== {1'b0, 4'b0000, 8'd1}) begin
            errors++;
            $display("FAIL req_drop_ack got valid=%b grant=%b cnt=%0d want 0 0000 1",
                     valid, grant, grant_cnt);
        end
        tick(4'b0000, 1'b1);
        checks++;
        if ({valid, grant_cnt} !== {1'b0, 8'd1}) begin
            errors++;
            $display("FAIL idle_ack_ignored got valid=%b cnt=%0d want 0 1", valid, grant_cnt);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(4'b1111, 1'b0);
        tick(4'b1111, 1'b1);
        tick(4'b1000, 1'b1);
        tick(4'b1000, 1'b0);
        checks++;
        if ({valid, s1, s0} !== 3'b111) begin
            errors++;
            $display("FAIL async_setup got valid=%b s=%b%b want 1 11", valid, s1, s0);
        end
        rst = 1'b1;
        #2;
        checks++;
        if ({valid, grant, s1, s0, grant_cnt, to} !== {1'b0, 4'b0000, 2'b00, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got valid=%b grant=%b s=%b%b cnt=%0d want all zero",
                     valid, grant, s1, s0, grant_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick(4'b1000, 1'b0);
        checks++;
        if ({valid, grant, s1, s0} !== {1'b1, 4'b1000, 2'b11}) begin
            errors++;
            $display("FAIL after_reset got valid=%b grant=%b s=%b%b want 1 1000 11",
                     valid, grant, s1, s0);
        end
    endtask

    task automatic test_cnt_wrap();
        apply_reset();
        tick(4'b1111, 1'b1);
        for (int i = 0; i < 255; i++) tick(4'b1111, 1'b1);
        checks++;
        if (grant_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_max got %0d want 255", grant_cnt);
        end
        tick(4'b1111, 1'b1);
        checks++;
        if ({valid, grant_cnt} !== {1'b1, 8'd0}) begin
            errors++;
            $display("FAIL cnt_wrap got valid=%b cnt=%0d want 1 0", valid, grant_cnt);
        end
    endtask

`ifdef MUX_SEL_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int to_seen;
        apply_reset();
        to_seen = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            tick(4'b0011, 1'b0);
            if (to) to_seen++;
            checks++;
            if ({valid, grant} !== {1'b1, 4'b0001}) begin
                errors++;
                $display("FAIL timeout_hold cyc=%0d got valid=%b grant=%b want 1 0001", i, valid, grant);
            end
        end
        tick(4'b0011, 1'b0);
        checks++;
        if ({grant, to, grant_cnt} !== {4'b0010, 1'b1, 8'd0} || to_seen != 0) begin
            errors++;
            $display("FAIL timeout_release got grant=%b to=%b cnt=%0d early=%0d want 0010 1 0 0",
                     grant, to, grant_cnt, to_seen);
        end
        tick(4'b0011, 1'b0);
        checks++;
        if ({grant, to} !== {4'b0010, 1'b0}) begin
            errors++;
            $display("FAIL timeout_pulse got grant=%b to=%b want 0010 0", grant, to);
        end
    endtask
`endif

    task automatic test_random();
        logic [3:0] r;
        logic       a;
        logic [3:0] exp_grant;
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            r = 4'($urandom);
            if (($urandom % 4) == 0) r = 4'b0000;
            a = (($urandom % 3) != 0);
            tick(r, a);
            exp_grant = m_busy ? 4'(4'b0001 << m_sel) : 4'b0000;
            checks++;
            if (valid !== m_busy || grant !== exp_grant || grant_cnt !== CNT_W'(m_cnt) ||
                to !== m_to || (m_busy && {s1, s0} !== 2'(m_sel))) begin
                errors++;
                $display("FAIL random cyc=%0d got valid=%b grant=%b s=%b%b cnt=%0d to=%b want valid=%b grant=%b sel=%0d cnt=%0d to=%b",
                         i, valid, grant, s1, s0, grant_cnt, to, m_busy, exp_grant, m_sel, m_cnt, m_to);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_round_robin();
        test_hold();
        test_req_drop();
        test_async_reset();
        test_cnt_wrap();
`ifdef MUX_SEL_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the 4:1 mux.
- Watches four channel request lines and generates the mux select pair s1/s0 with a one-hot grant and a valid flag.
- Holds each grant until the consumer acknowledges, so the mux output stays stable for a full transfer.
- Channels get fair, wrap-around access; back-to-back grants need no idle cycle.

Parameters:
- CNT_W, 8, width of the completed-grant counter.
- TIMEOUT, 16, cycles a grant may stay unacknowledged before forced release (used only with the optional feature; must be ≥ 2).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  request per channel; req[0]=a, req[1]=b, req[2]=c, req[3]=d.
- ack  input  1  consumer has taken the current mux output; meaningful only while valid=1.
- s0  output  1  select LSB to the mux.
- s1  output  1  select MSB to the mux.
- grant  output  4  one-hot grant, consistent with {s1,s0}.
- valid  output  1  a grant is active and the mux output is meaningful.
- grant_cnt  output  CNT_W  number of acknowledged grants; wraps modulo 2^CNT_W.
- to  output  1  one-cycle pulse on forced release (tied 0 without the optional feature).

Behaviour:
- Reset (async, any time, including mid-grant):
  - s0=0, s1=0, grant=0, valid=0, grant_cnt=0, to=0.
  - Internal pointer ptr=3, so channel 0 has top priority first.
  - State=IDLE; timeout counter=0.
- States: IDLE, GRANT.
- Winner search: start at index (ptr+1) mod 4, step upward with wrap, take the first index whose req bit is 1.
- IDLE:
  - valid=0, grant=0. s1/s0 hold their last value (0 after reset).
  - If req≠0 at a clock edge: load the winner into {s1,s0}, set grant=1<<winner, valid=1, go to GRANT.
  - Latency: req asserted before edge N gives valid=1 after edge N (one cycle).
- GRANT:
  - valid=1; s1, s0 and grant are frozen.
  - The req bit of the granted channel may drop; the grant is still held until ack.
  - On ack=1 at an edge: ptr←current index; grant_cnt←grant_cnt+1 (wraps from 2^CNT_W−1 to 0).
  - The winner is recomputed from the req value sampled that same cycle, using the updated ptr.
  - If that winner exists: stay in GRANT, load the new index (back-to-back, valid stays 1).
  - Otherwise: go to IDLE with valid=0.
  - The just-served channel can win again only if no other channel requests.
- ack while valid=0 is ignored; no counter change.
- req changes during GRANT have no effect until the next arbitration point.
- Simultaneous ack and req change: the new req value is used for the next winner.
- grant is always one-hot or zero, and always equals 1<<{s1,s0} whenever valid=1.

Optional Feature:
- Macro: MUX_SEL_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to GRANT (including back-to-back reloads) and increments each GRANT cycle without ack.
  - Once it reaches TIMEOUT−1 with ack=0, the next edge acts as a release:
    - ptr advances as for ack;
    - the next winner is arbitrated;
    - grant_cnt is NOT incremented;
    - to pulses 1 for exactly one cycle.
  - ack arriving on the same cycle as the limit counts as a normal ack; no pulse.
- Not defined: no timeout counter; the grant waits indefinitely for ack; to is constant 0.

Test Plan:
- Reset release with req=4'b0000 for 5 cycles -> valid=0, grant=0, s1s0=00, grant_cnt=0.
- req=4'b1111 held, ack=1 every cycle in GRANT -> s1s0 sequence 00,01,10,11,00 with valid continuously 1; grant_cnt=4 after the fourth ack.
- req=4'b0100 only, ack after 3 cycles -> grant=4'b0100, s1s0=10 stable for 3 cycles; then valid=0 one cycle after ack; grant_cnt=1.
- Granted channel drops req before ack (req 4'b0010→4'b0000) -> grant stays 4'b0010 until ack, then IDLE.
- rst pulsed while in GRANT with s1s0=11 -> all outputs 0 immediately (no clock needed); after release with req=4'b1000 -> channel 3 granted (ptr=3 search from 0 finds 3).
- With MUX_SEL_ARB_TIMEOUT_EN, TIMEOUT=16, req=4'b0011, ack=0 -> channel 0 held 16 cycles; to pulses once; grant moves to channel 1; grant_cnt remains 0.
